// File: rtl/instruction_mem_pkg.sv
// Shared constants for the loadable instruction store: NOP encoding and
// controller state type.
package instruction_mem_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    localparam logic [4:0] NOP_OPCODE = 5'b00100;

    function automatic logic [31:0] set_opcode(input logic [4:0] opc);
        logic [31:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB] = opc;
        return w;
    endfunction

    localparam logic [31:0] NOP_WORD = set_opcode(NOP_OPCODE);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_ram_core.sv
// DEPTH x DATA_WIDTH simple dual-port RAM: one synchronous write port,
// one synchronous read port whose output holds while the read is idle.
module instruction_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clock) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction RAM: NOP scrub after reset, streaming
// program-load port, and a registered fetch port with range faults.
module instruction_memory_loadable #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(instruction_mem_pkg::NOP_WORD)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic [ADDR_WIDTH:0]   load_count,
    input  logic                  fetch_enable,
    input  logic [31:0]           fetch_address,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  fetch_fault,
    output logic                  busy
);
    import instruction_mem_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [31:0]           DEPTH32  = 32'(DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH:0]   r_load_count;
    logic                  r_overflow;
    logic                  r_done;
    logic                  r_fvalid;
    logic                  r_ffault;
    logic                  r_fnop;

    logic                  w_serve;
    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_serve    = (r_state == ST_READY) && fetch_enable;
    assign w_in_range = fetch_address < DEPTH32;
    assign w_accept   = (r_state == ST_LOAD) && load_valid;
    assign w_we       = !reset && ((r_state == ST_CLEAR) || w_accept);
    assign w_waddr    = (r_state == ST_CLEAR) ? r_clr_addr : r_load_count[ADDR_WIDTH-1:0];
    assign w_wdata    = (r_state == ST_CLEAR) ? NOP_WORD : load_data;
    assign w_re       = !reset && w_serve && w_in_range;

    instruction_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (fetch_address[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_load_count <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == CLR_LAST) r_state <= ST_READY;
                end
                ST_READY: begin
                    if (load_start) begin
                        r_state      <= ST_LOAD;
                        r_load_count <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        r_load_count <= r_load_count + 1'b1;
                        if (load_last || r_load_count == CNT_LAST) begin
                            r_state <= ST_READY;
                            r_done  <= 1'b1;
                        end
                        if (!load_last && r_load_count == CNT_LAST) r_overflow <= 1'b1;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // r_fnop selects the bubble word; when idle in READY both it and the RAM
    // read register hold, so fetch_data keeps its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fvalid <= 1'b0;
            r_ffault <= 1'b0;
            r_fnop   <= 1'b1;
        end else begin
            r_fvalid <= w_serve;
            r_ffault <= w_serve && !w_in_range;
            if (r_state != ST_READY) r_fnop <= 1'b1;
            else if (fetch_enable)   r_fnop <= !w_in_range;
        end
    end

    assign load_ready    = (r_state == ST_LOAD);
    assign busy          = (r_state != ST_READY);
    assign load_done     = r_done;
    assign load_overflow = r_overflow;
    assign load_count    = r_load_count;
    assign fetch_valid   = r_fvalid;
    assign fetch_fault   = r_ffault;
    assign fetch_data    = r_fnop ? NOP_WORD : w_rdata;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomized bench for instruction_memory_loadable (DEPTH=32) with an
// abstract memory/phase model and literal spot checks.
module tb_instruction_memory_loadable;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam logic [31:0] NOP = 32'h2000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic [AW:0]   load_count;
    logic          fetch_enable = 1'b0;
    logic [31:0]   fetch_address = '0;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          fetch_fault;
    logic          busy;

    instruction_memory_loadable #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_last     (load_last),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .load_overflow (load_overflow),
        .load_count    (load_count),
        .fetch_enable  (fetch_enable),
        .fetch_address (fetch_address),
        .fetch_data    (fetch_data),
        .fetch_valid   (fetch_valid),
        .fetch_fault   (fetch_fault),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Abstract model: scrub cycles remaining, a loading flag, and the memory image.
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left = 0;
    bit          m_loading = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          m_done = 0;
    bit          m_fv = 0;
    bit          m_ff = 0;
    logic [31:0] m_fd = NOP;
    bit          m_live = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_clear_left = DEPTH;
            m_loading = 0;
            m_cnt = 0;
            m_ovf = 0;
            m_done = 0;
            m_fv = 0;
            m_ff = 0;
            m_fd = NOP;
            m_live = 1;
        end else if (m_live) begin
            m_done = 0;
            if (m_clear_left == 0 && !m_loading) begin
                if (fetch_enable) begin
                    m_fv = 1;
                    m_ff = (fetch_address >= DEPTH);
                    m_fd = m_ff ? NOP : m_mem[int'(fetch_address)];
                end else begin
                    m_fv = 0;
                    m_ff = 0;
                end
            end else begin
                m_fv = 0;
                m_ff = 0;
                m_fd = NOP;
            end
            if (m_clear_left > 0) begin
                m_mem[DEPTH - m_clear_left] = NOP;
                m_clear_left--;
            end else if (m_loading) begin
                if (load_valid) begin
                    m_mem[m_cnt] = load_data;
                    m_cnt++;
                    if (load_last || m_cnt == DEPTH) begin
                        m_loading = 0;
                        m_done = 1;
                        if (!load_last) m_ovf = 1;
                    end
                end
            end else if (load_start) begin
                m_loading = 1;
                m_cnt = 0;
                m_ovf = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("busy",          32'(busy),          32'(m_clear_left > 0 || m_loading));
            chk("load_ready",    32'(load_ready),    32'(m_loading));
            chk("load_done",     32'(load_done),     32'(m_done));
            chk("load_overflow", 32'(load_overflow), 32'(m_ovf));
            chk("load_count",    32'(load_count),    32'(m_cnt));
            chk("fetch_valid",   32'(fetch_valid),   32'(m_fv));
            chk("fetch_fault",   32'(fetch_fault),   32'(m_ff));
            chk("fetch_data",    fetch_data,         m_fd);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_enable = 1'b1;
        fetch_address = a;
        tick();
        fetch_enable = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input bit last, input int gap);
        load_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        load_valid = 1'b1;
        load_data = d;
        load_last = last;
        tick();
        load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    logic [31:0] prog [3];

    initial begin
        prog[0] = 32'h5E80_0001;
        prog[1] = 32'h5F00_0002;
        prog[2] = 32'h6780_0000;
        tick();

        // Reset and scrub
        do_reset();
        chk("lit_reset_busy", 32'(busy), 32'd1);
        chk("lit_reset_fdata", fetch_data, NOP);
        chk("lit_reset_count", 32'(load_count), 32'd0);
        for (int i = 0; i < 31; i++) tick();
        chk("lit_busy_c32", 32'(busy), 32'd1);
        tick();
        chk("lit_busy_done", 32'(busy), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            fetch(32'(a));
            chk("lit_scrub_nop", fetch_data, NOP);
        end

        // Three-word program with gaps
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 3; i++) push(prog[i], i == 2, i + 1);
        chk("lit_done3", 32'(load_done), 32'd1);
        chk("lit_count3", 32'(load_count), 32'd3);
        tick();
        chk("lit_done3_off", 32'(load_done), 32'd0);
        for (int a = 0; a < 3; a++) begin
            fetch(32'(a));
            chk("lit_prog_word", fetch_data, prog[a]);
        end
        fetch(32'd3);
        chk("lit_word3_nop", fetch_data, NOP);

        // Overflow load, with a blocked fetch and an ignored load_start inside
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 10) begin
                load_start = 1'b1;
                fetch_enable = 1'b1;
                fetch_address = 32'd5;
                push($urandom, 1'b0, 0);
                load_start = 1'b0;
                fetch_enable = 1'b0;
                chk("lit_load_fv", 32'(fetch_valid), 32'd0);
                chk("lit_load_fd", fetch_data, NOP);
                chk("lit_load_cnt", 32'(load_count), 32'd11);
            end else begin
                push($urandom, 1'b0, $urandom_range(0, 2));
            end
        end
        chk("lit_ovf_ready", 32'(load_ready), 32'd0);
        chk("lit_ovf_done", 32'(load_done), 32'd1);
        chk("lit_ovf_flag", 32'(load_overflow), 32'd1);
        chk("lit_ovf_count", 32'(load_count), 32'd32);
        tick();
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("lit_ovf_clear", 32'(load_overflow), 32'd0);
        push(32'h1234_5678, 1'b1, 0);

        // Out-of-range fetches
        fetch(32'd32);
        chk("lit_oor_fault", 32'(fetch_fault), 32'd1);
        chk("lit_oor_valid", 32'(fetch_valid), 32'd1);
        chk("lit_oor_data", fetch_data, NOP);
        fetch(32'hFFFF_FFFF);
        chk("lit_max_fault", 32'(fetch_fault), 32'd1);
        chk("lit_max_data", fetch_data, NOP);
        tick();
        chk("lit_oor_fault_off", 32'(fetch_fault), 32'd0);
        chk("lit_oor_valid_off", 32'(fetch_valid), 32'd0);

        // Reset in the middle of a load
        load_start = 1'b1; tick(); load_start = 1'b0;
        push(32'hDEAD_0001, 1'b0, 0);
        push(32'hDEAD_0002, 1'b0, 0);
        do_reset();
        chk("lit_midrst_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 32; i++) tick();
        fetch(32'd0);
        chk("lit_midrst_w0", fetch_data, NOP);
        fetch(32'd1);
        chk("lit_midrst_w1", fetch_data, NOP);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset         = ($urandom_range(0, 599) == 0);
            load_start    = ($urandom_range(0, 19) == 0);
            load_valid    = $urandom_range(0, 1) == 1;
            load_last     = ($urandom_range(0, 11) == 0);
            load_data     = $urandom;
            fetch_enable  = ($urandom_range(0, 2) != 0);
            fetch_address = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            tick();
        end
        reset = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        fetch_enable = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
